// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: state codes, opcodes, widths.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (illegal-opcode trapping).
package alu_ctrl_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned RES_W   = 16;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 4;

    // Codes 1 and 7 are deliberately unused and recover to IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_B  = 3'd2,
        ST_LOAD_OP = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WB      = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_MUL   = 4'h3;
    localparam logic [OP_W-1:0] OP_ANDID = 4'h4;

    // Opcodes 0xD..0xF are reserved and trapped when trapping is built in.
    localparam logic [OP_W-1:0] OP_ILLEGAL_LO = 4'hD;
    localparam logic [OP_W-1:0] OP_ILLEGAL_HI = 4'hF;

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op >= OP_ILLEGAL_LO) && (op <= OP_ILLEGAL_HI);
    endfunction

endpackage

// File: rtl/alu_control_fsm_enter_edge_detect.sv
// Rising-edge detector for the operator step input.
// The history flop resets to 1 so a level held through reset release is not an event.
module enter_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic enter,
    output logic step_c
);

    logic enter_q;

    // One-cycle history of enter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enter_q <= 1'b1;
        end else begin
            enter_q <= enter;
        end
    end

    assign step_c = enter & ~enter_q;

endmodule

// File: rtl/alu_control_fsm.sv
// Operator-driven sequencer for an external ALU core: collects operand A,
// operand B and the opcode on successive enter steps, waits EXEC_CYCLES for
// the core to settle, then captures its result.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN (trap reserved opcodes
// straight to DONE with a zero result and illegal_op set).
module alu_control_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enter,
    input  logic [7:0]  data_in,
    input  logic        abort,
    input  logic [15:0] core_out,
    output logic [3:0]  opcode,
    output logic [7:0]  opA,
    output logic [7:0]  opB,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [2:0]  state,
    output logic        illegal_op
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  opa_q, opa_d;
    logic [DATA_W-1:0]  opb_q, opb_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_c;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    enter_edge_detect u_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .enter   (enter),
        .step_c  (step_c)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            opcode_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state and next-register values; abort overrides any step.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opcode_d = opcode_q;
        result_d = result_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        if (abort) begin
            state_d  = ST_IDLE;
            opa_d    = '0;
            opb_d    = '0;
            opcode_d = '0;
            result_d = '0;
            valid_d  = 1'b0;
            cnt_d    = '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            if (step_c) begin
                illegal_d = 1'b0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (step_c) begin
                        opa_d   = data_in;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (step_c) begin
                        opb_d   = data_in;
                        state_d = ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (step_c) begin
                        opcode_d = data_in[OP_W-1:0];
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        if (is_illegal_op(data_in[OP_W-1:0])) begin
                            result_d  = '0;
                            valid_d   = 1'b1;
                            illegal_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            cnt_d   = CNT_W'(EXEC_CYCLES);
                            state_d = ST_EXEC;
                        end
`else
                        cnt_d   = CNT_W'(EXEC_CYCLES);
                        state_d = ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    // Steps here are dropped; operands stay frozen for the core.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_WB;
                    end
                end
                ST_WB: begin
                    result_d = core_out;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    // A step chains straight into the next operation's operand A.
                    if (step_c) begin
                        valid_d = 1'b0;
                        opa_d   = data_in;
                        state_d = ST_LOAD_B;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_EXEC) || (state_d == ST_WB);
    end

    assign opcode       = opcode_q;
    assign opA          = opa_q;
    assign opB          = opb_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign state        = STATE_W'(state_q);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op   = illegal_q;
`else
    assign illegal_op   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_fsm.sv
// Self-checking bench for alu_control_fsm with a behavioural ALU core and a
// transaction-level expectation model (operands in, result and latency out).
module tb_alu_control_fsm;

    localparam int unsigned N = 2;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        enter;
    logic [7:0]  data_in;
    logic        abort;
    logic [15:0] core_out;
    logic [3:0]  opcode;
    logic [7:0]  opA;
    logic [7:0]  opB;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic [2:0]  state;
    logic        illegal_op;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    alu_control_fsm #(.EXEC_CYCLES(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enter        (enter),
        .data_in      (data_in),
        .abort        (abort),
        .core_out     (core_out),
        .opcode       (opcode),
        .opA          (opA),
        .opB          (opB),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .state        (state),
        .illegal_op   (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural downstream ALU core.
    function automatic logic [15:0] core_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        case (op)
            4'h0: begin t = a + b; return {8'h00, t}; end
            4'h1: begin t = a - b; return {8'h00, t}; end
            4'h2: return {8'h00, a & b};
            4'h3: return 16'(a) * 16'(b);
            4'h4: return {8'h00, a | b};
            4'h5: return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    assign core_out = core_fn(opcode, opA, opB);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clean enter pulse presenting v; returns at the negedge after the step edge.
    task automatic step(input logic [7:0] v);
        @(negedge clock);
        data_in = v;
        enter   = 1'b1;
        @(negedge clock);
        enter   = 1'b0;
        data_in = 8'($urandom);
    endtask

    // Full operation with expectations derived from the operands and opcode.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input string tag);
        int          n;
        int          bcnt;
        int          exp_lat;
        logic        trapped;
        logic [15:0] exp_res;
        trapped = TRAP && (op >= 4'hD);
        exp_lat = trapped ? 0 : int'(N) + 1;
        exp_res = trapped ? 16'h0000 : core_fn(op, a, b);

        step(a);
        chk({tag, ".stA"}, 32'(state), 32'd2);
        chk({tag, ".opA"}, 32'(opA), 32'(a));
        chk({tag, ".vclr"}, 32'(result_valid), 32'd0);
        chk({tag, ".illclr"}, 32'(illegal_op), 32'd0);
        step(b);
        chk({tag, ".stB"}, 32'(state), 32'd3);
        chk({tag, ".opB"}, 32'(opB), 32'(b));

        @(negedge clock);
        data_in = {4'($urandom), op};
        enter   = 1'b1;
        @(negedge clock);
        enter   = 1'b0;
        n    = 0;
        bcnt = 0;
        while (result_valid !== 1'b1 && n < 64) begin
            if (busy === 1'b1) bcnt = bcnt + 1;
            data_in = 8'($urandom);
            @(negedge clock);
            n = n + 1;
        end
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".busy"}, 32'(bcnt), 32'(exp_lat));
        chk({tag, ".res"}, 32'(result), 32'(exp_res));
        chk({tag, ".stD"}, 32'(state), 32'd6);
        chk({tag, ".ill"}, 32'(illegal_op), 32'(trapped));
        chk({tag, ".hold"}, {opcode, opA, opB}, {op, a, b});
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [3:0]  rop;
        logic [15:0] saved;

        reset_n = 1'b0;
        enter   = 1'b0;
        abort   = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clock);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.outs", {opcode, opA, opB, result_valid, busy, illegal_op}, 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(8'h05, 8'hFD, 4'h0, "add");
        repeat (5) begin
            @(negedge clock);
            data_in = 8'($urandom);
        end
        chk("add.keep", {result, 7'd0, result_valid, 5'd0, state}, {16'h0002, 7'd0, 1'b1, 5'd0, 3'd6});

        run_op(8'h0C, 8'h0A, 4'h3, "mul");
        run_op(8'h33, 8'h44, 4'hE, "opE");

        // enter held high in LOAD_B: a single capture.
        step(8'h11);
        @(negedge clock);
        data_in = 8'h5A;
        enter   = 1'b1;
        repeat (10) begin
            @(negedge clock);
            data_in = 8'($urandom);
        end
        chk("hold.opB", 32'(opB), 32'h5A);
        chk("hold.state", 32'(state), 32'd3);
        enter = 1'b0;
        @(negedge clock);
        chk("hold.state2", 32'(state), 32'd3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abrt1.state", 32'(state), 32'd0);
        chk("abrt1.ops", {opcode, opA, opB}, 32'd0);

        // abort coinciding with a step in EXEC.
        step(8'h07);
        step(8'h09);
        step(8'h00);
        chk("abx.inexec", 32'(state), 32'd4);
        data_in = 8'hFF;
        enter   = 1'b1;
        abort   = 1'b1;
        @(negedge clock);
        abort   = 1'b0;
        enter   = 1'b0;
        chk("abx.state", 32'(state), 32'd0);
        chk("abx.outs", {opcode, opA, opB, result_valid, busy, illegal_op}, 32'd0);
        chk("abx.result", 32'(result), 32'd0);
        repeat (N + 3) @(negedge clock);
        chk("abx.nocap", {result, 5'd0, state, 7'd0, result_valid}, 32'd0);

        // reset mid-EXEC with enter held through release.
        step(8'h21);
        step(8'h03);
        step(8'h03);
        chk("rx.inexec", 32'(state), 32'd4);
        enter = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rx.async", {5'd0, state, 7'd0, result_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("rx.noevt", {5'd0, state, opA}, 32'd0);
        chk("rx.noval", {result, 7'd0, result_valid}, 32'd0);
        enter = 1'b0;
        @(negedge clock);

        // Randomized operations, chained from DONE, with idle gaps.
        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 4'($urandom_range(15));
            run_op(ra, rb, rop, "rnd");
            saved = result;
            repeat ($urandom_range(3)) begin
                @(negedge clock);
                data_in = 8'($urandom);
            end
            chk("rnd.idle", {result, 7'd0, result_valid}, {saved, 7'd0, 1'b1});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
